// File: rtl/mm_pkg.sv
// Shared types and defaults for the output-stationary systolic matrix-multiply engine.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int N_DEF      = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 32;
    localparam int K_W_DEF    = 8;

    localparam int FLUSH_LEN_DEF = 2 * N_DEF - 2;

    // Zero-operand advances needed after the last step so the far corner PE sees its product.
    function automatic int flush_len(input int n);
        return 2 * n - 2;
    endfunction

endpackage

// File: rtl/mm_pe.sv
// One processing element: forwards a right and b down, accumulates a*b on every advance.
module mm_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv,
    input  logic              clr,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    // Full-width product, sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] ext_product(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              sgn
    );
        logic signed [2*DATA_W-1:0] p_s;
        logic        [2*DATA_W-1:0] p_u;
        logic signed [ACC_W-1:0]    e_s;
        logic        [ACC_W-1:0]    e_u;
        p_s = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        p_u = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        e_s = ACC_W'(p_s);
        e_u = ACC_W'(p_u);
        return sgn ? $unsigned(e_s) : e_u;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else if (adv) begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + ext_product(a_in, b_in, is_signed);
        end
    end

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic array computing C = A*B with runtime K,
// internal input skewing, zero flush and backpressured row-by-row drain.
module systolic_mm_engine
    import mm_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_W    = K_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [K_W-1:0]        k_len,
    input  logic                  is_signed,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*DATA_W-1:0]   a_col,
    input  logic [N*DATA_W-1:0]   b_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [$clog2(N)-1:0]  out_row,
    output logic [N*ACC_W-1:0]    out_data,
    output logic                  busy,
    output logic                  done
);

    localparam int FLUSH_LEN = flush_len(N);
    localparam int RW        = $clog2(N);
    localparam int FW        = $clog2(FLUSH_LEN);

    state_t           state, nxt;
    logic [K_W-1:0]   k_q, k_cnt;
    logic [FW-1:0]    f_cnt;
    logic             sgn_q;
    logic             adv, clr, done_nxt, flushing;

    logic [DATA_W-1:0] a_h   [N][N+1];
    logic [DATA_W-1:0] b_v   [N+1][N];
    logic [ACC_W-1:0]  acc_w [N][N];

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt      = state;
        adv      = 1'b0;
        clr      = 1'b0;
        done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    nxt = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    adv = 1'b1;
                    if (k_cnt == k_q - K_W'(1)) nxt = FLUSH;
                end
            end
            FLUSH: begin
                adv = 1'b1;
                if (f_cnt == FW'(FLUSH_LEN - 1)) nxt = DRAIN;
            end
            DRAIN: begin
                if (out_ready && out_row == RW'(N - 1)) begin
                    nxt      = IDLE;
                    done_nxt = 1'b1;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // Job bookkeeping: latched job parameters, step/flush counters and drain row pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_q     <= '0;
            sgn_q   <= 1'b0;
            k_cnt   <= '0;
            f_cnt   <= '0;
            out_row <= '0;
            done    <= 1'b0;
        end else begin
            done <= done_nxt;
            if (state == IDLE && start) begin
                k_q     <= k_len;
                sgn_q   <= is_signed;
                k_cnt   <= '0;
                f_cnt   <= '0;
                out_row <= '0;
            end
            if (state == LOAD && in_valid) k_cnt <= k_cnt + K_W'(1);
            if (state == FLUSH)            f_cnt <= f_cnt + FW'(1);
            if (state == DRAIN && out_ready)
                out_row <= (out_row == RW'(N - 1)) ? '0 : out_row + RW'(1);
        end
    end

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign flushing  = (state == FLUSH);

    // Lane l of A and of B is delayed l advances before entering the array edge.
    for (genvar gl = 0; gl < N; gl++) begin : g_skew
        logic [DATA_W-1:0] a_src, b_src;
        assign a_src = flushing ? '0 : a_col[gl*DATA_W +: DATA_W];
        assign b_src = flushing ? '0 : b_row[gl*DATA_W +: DATA_W];

        if (gl == 0) begin : g_direct
            assign a_h[0][0] = a_src;
            assign b_v[0][0] = b_src;
        end else begin : g_delay
            logic [DATA_W-1:0] a_dly [gl];
            logic [DATA_W-1:0] b_dly [gl];
            always_ff @(posedge clk) begin
                if (!rst_n || clr) begin
                    for (int s = 0; s < gl; s++) begin
                        a_dly[s] <= '0;
                        b_dly[s] <= '0;
                    end
                end else if (adv) begin
                    a_dly[0] <= a_src;
                    b_dly[0] <= b_src;
                    for (int s = 1; s < gl; s++) begin
                        a_dly[s] <= a_dly[s-1];
                        b_dly[s] <= b_dly[s-1];
                    end
                end
            end
            assign a_h[gl][0] = a_dly[gl-1];
            assign b_v[0][gl] = b_dly[gl-1];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            mm_pe #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk       (clk),
                .rst_n     (rst_n),
                .adv       (adv),
                .clr       (clr),
                .is_signed (sgn_q),
                .a_in      (a_h[gi][gj]),
                .b_in      (b_v[gi][gj]),
                .a_out     (a_h[gi][gj+1]),
                .b_out     (b_v[gi+1][gj]),
                .acc       (acc_w[gi][gj])
            );
        end
    end

    // Accumulators are frozen during DRAIN, so the selected row is stable while stalled.
    always_comb begin
        out_data = '0;
        if (state == DRAIN) begin
            for (int j = 0; j < N; j++)
                out_data[j*ACC_W +: ACC_W] = acc_w[out_row][j];
        end
    end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine (N=4): results, latency, stalls, k=0, back-to-back and abort.
module tb_systolic_mm_engine;

    localparam int N      = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int K_W    = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [K_W-1:0]       k_len;
    logic                 is_signed;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DATA_W-1:0]  a_col;
    logic [N*DATA_W-1:0]  b_row;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_row;
    logic [N*ACC_W-1:0]   out_data;
    logic                 busy;
    logic                 done;

    always #5 clk = ~clk;

    systolic_mm_engine #(
        .N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .K_W(K_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .is_signed(is_signed),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    int          a_m   [4][8];
    int          b_m   [8][4];
    logic [31:0] c_res [4][4];
    logic [31:0] c_ref [4][4];

    int lat, stab_err, order_err, rows_seen;
    bit tmo, saw_ready;

    function automatic longint ext8(input int v, input bit sgn);
        logic [7:0] b8;
        b8 = 8'(v);
        return sgn ? longint'($signed(b8)) : longint'(b8);
    endfunction

    task automatic compute_ref(input int k, input bit sgn);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                longint s;
                s = 0;
                for (int kk = 0; kk < k; kk++) s += ext8(a_m[i][kk], sgn) * ext8(b_m[kk][j], sgn);
                c_ref[i][j] = 32'(s);
            end
    endtask

    task automatic set_identity();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = (i == k) ? 1 : 0;
                b_m[k][i] = 4 * k + i + 1;
            end
    endtask

    task automatic set_signed_data();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 3; k++) begin
                a_m[i][k] = i + k;
                b_m[k][i] = k - i;
            end
    endtask

    task automatic set_all(input int v, input int k);
        for (int i = 0; i < 4; i++)
            for (int kk = 0; kk < k; kk++) begin
                a_m[i][kk] = v;
                b_m[kk][i] = v;
            end
    endtask

    // Drives one job from the current negedge; returns at the negedge where done is seen.
    task automatic run_job(input int k, input bit sgn, input int vpct, input int rpct,
                           input bit start_in_load);
        int s, exp_row;
        bit prev_stall, rdy, v;
        logic [1:0]         p_row;
        logic [N*ACC_W-1:0] p_data;
        s = 0; exp_row = 0; prev_stall = 0; p_row = '0; p_data = '0;
        rows_seen = 0; stab_err = 0; order_err = 0; saw_ready = 0; tmo = 0; lat = -1;
        start = 1'b1; k_len = K_W'(k); is_signed = sgn; in_valid = 1'b0; out_ready = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start     = (start_in_load && c == 2);
            k_len     = (start_in_load && c == 2) ? '0 : K_W'(k);
            is_signed = (start_in_load && c == 2) ? ~sgn : sgn;
            if (done) begin
                lat = c;
                break;
            end
            if (out_valid) begin
                if (prev_stall && (out_row !== p_row || out_data !== p_data)) stab_err++;
                if (out_row !== 2'(exp_row)) order_err++;
            end
            rdy = ($urandom_range(99) < rpct);
            out_ready = rdy;
            if (out_valid && rdy) begin
                for (int j = 0; j < 4; j++) c_res[out_row][j] = out_data[j*ACC_W +: ACC_W];
                rows_seen++;
                exp_row++;
            end
            prev_stall = out_valid && !rdy;
            p_row  = out_row;
            p_data = out_data;
            if (in_ready) begin
                saw_ready = 1;
                v = (s < k) && ($urandom_range(99) < vpct);
                in_valid = v;
                for (int i = 0; i < 4; i++) begin
                    a_col[i*DATA_W +: DATA_W] = (s < k) ? 8'(a_m[i][s]) : 8'hEE;
                    b_row[i*DATA_W +: DATA_W] = (s < k) ? 8'(b_m[s][i]) : 8'hEE;
                end
                if (v) s++;
            end else begin
                in_valid = 1'($urandom_range(1));
                a_col = $urandom;
                b_row = $urandom;
            end
        end
        if (lat < 0) tmo = 1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; k_len = '0; is_signed = 1'b0;
        in_valid = 1'b0; a_col = '0; b_row = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (out_row !== 2'd0) begin errors++; $display("FAIL reset_out_row got %0d want 0", out_row); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    endtask

    task automatic test_identity();
        set_identity();
        run_job(4, 1'b0, 100, 100, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL ident_timeout got %b want 0", tmo); end
        checks++; if (lat != 15) begin errors++; $display("FAIL ident_latency got %0d want 15", lat); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL ident_row_order got %0d want 0", order_err); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== 32'(4 * i + j + 1)) begin
                    errors++;
                    $display("FAIL ident_c[%0d][%0d] got %0d want %0d", i, j, c_res[i][j], 4 * i + j + 1);
                end
            end
    endtask

    task automatic test_signed();
        set_signed_data();
        compute_ref(3, 1'b1);
        run_job(3, 1'b1, 100, 100, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL signed_timeout got %b want 0", tmo); end
        checks++; if (c_res[0][3] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL signed_c03 got %h want fffffffc", c_res[0][3]); end
        checks++; if (c_res[3][0] !== 32'd14) begin errors++; $display("FAIL signed_c30 got %0d want 14", c_res[3][0]); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== c_ref[i][j]) begin
                    errors++;
                    $display("FAIL signed_c[%0d][%0d] got %h want %h", i, j, c_res[i][j], c_ref[i][j]);
                end
            end
    endtask

    task automatic test_extremes();
        set_all(255, 2);
        run_job(2, 1'b0, 100, 100, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== 32'd130050) begin
                    errors++;
                    $display("FAIL uns255_c[%0d][%0d] got %0d want 130050", i, j, c_res[i][j]);
                end
            end
        run_job(2, 1'b1, 100, 100, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== 32'd2) begin
                    errors++;
                    $display("FAIL sgn255_c[%0d][%0d] got %0d want 2", i, j, c_res[i][j]);
                end
            end
    endtask

    task automatic test_stalls();
        set_signed_data();
        compute_ref(3, 1'b1);
        run_job(3, 1'b1, 50, 50, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b want 0", tmo); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stab_err); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL stall_row_order got %0d want 0", order_err); end
        checks++; if (rows_seen != 4) begin errors++; $display("FAIL stall_rows got %0d want 4", rows_seen); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== c_ref[i][j]) begin
                    errors++;
                    $display("FAIL stall_c[%0d][%0d] got %h want %h", i, j, c_res[i][j], c_ref[i][j]);
                end
            end
    endtask

    task automatic test_k0_and_start_ignored();
        run_job(0, 1'b0, 100, 60, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL k0_timeout got %b want 0", tmo); end
        checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL k0_in_ready got %b want 0", saw_ready); end
        checks++; if (rows_seen != 4) begin errors++; $display("FAIL k0_rows got %0d want 4", rows_seen); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== 32'd0) begin
                    errors++;
                    $display("FAIL k0_c[%0d][%0d] got %0d want 0", i, j, c_res[i][j]);
                end
            end
        set_identity();
        run_job(4, 1'b0, 100, 100, 1'b1);
        checks++; if (lat != 15) begin errors++; $display("FAIL ignstart_latency got %0d want 15", lat); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== 32'(4 * i + j + 1)) begin
                    errors++;
                    $display("FAIL ignstart_c[%0d][%0d] got %0d want %0d", i, j, c_res[i][j], 4 * i + j + 1);
                end
            end
    endtask

    task automatic test_back_to_back();
        set_identity();
        run_job(4, 1'b0, 100, 100, 1'b0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done_busy got done=%b busy=%b want 1/0", done, busy); end
        set_signed_data();
        compute_ref(3, 1'b1);
        run_job(3, 1'b1, 100, 100, 1'b0);
        checks++; if (lat != 14) begin errors++; $display("FAIL b2b_latency got %0d want 14", lat); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== c_ref[i][j]) begin
                    errors++;
                    $display("FAIL b2b_c[%0d][%0d] got %h want %h", i, j, c_res[i][j], c_ref[i][j]);
                end
            end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_pulse got %b want 0", done); end
    endtask

    task automatic test_reset_abort();
        set_identity();
        start = 1'b1; k_len = 8'd4; is_signed = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            start = 1'b0;
            in_valid = (c <= 4);
            for (int i = 0; i < 4; i++) begin
                a_col[i*DATA_W +: DATA_W] = (c <= 4) ? 8'(a_m[i][c-1]) : 8'h00;
                b_row[i*DATA_W +: DATA_W] = (c <= 4) ? 8'(b_m[c-1][i]) : 8'h00;
            end
        end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_flush got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_ready_valid got %b/%b want 0/0", in_ready, out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (out_row !== 2'd0 || out_data !== '0) begin errors++; $display("FAIL abort_out got row=%0d data=%h want 0", out_row, out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        set_all(1, 1);
        run_job(1, 1'b0, 100, 100, 1'b0);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL abort_job_timeout got %b want 0", tmo); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (c_res[i][j] !== 32'd1) begin
                    errors++;
                    $display("FAIL abort_c[%0d][%0d] got %0d want 1", i, j, c_res[i][j]);
                end
            end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_identity();
        @(negedge clk);
        test_signed();
        @(negedge clk);
        test_extremes();
        @(negedge clk);
        test_stalls();
        @(negedge clk);
        test_k0_and_start_ignored();
        @(negedge clk);
        test_back_to_back();
        @(negedge clk);
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_mm_engine.md
# systolic_mm_engine

Parametrised N×N output-stationary systolic matrix-multiply engine, the successor to the fixed 4×4 array. Computes C = A·B for A (N×K) and B (K×N) with runtime K. Input skewing, accumulator clearing, stall-able streaming input and backpressured row-by-row result drain are all internal. Sits between the operand buffers and the result writeback path.

## Interface
- N, default 4: array dimension (rows = cols), ≥ 2
- DATA_W, default 8: operand width
- ACC_W, default 32: accumulator width, ≥ 2·DATA_W
- K_W, default 8: width of k_len
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- start  in  1  begin job; sampled only in IDLE
- k_len  in  K_W  inner dimension K, latched on accepted start
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched on start
- in_valid  in  1  operand step valid
- in_ready  out  1  engine accepts a step
- a_col  in  N·DATA_W  column k of A; lane i = A[i][k]
- b_row  in  N·DATA_W  row k of B; lane j = B[k][j]
- out_valid  out  1  result row valid
- out_ready  in  1  consumer accepts row
- out_row  out  clog2(N)  index of row on out_data
- out_data  out  N·ACC_W  lane j = C[out_row][j]
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse after last row accepted

## Operation
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE + start:
  - Clear all accumulators.
  - Latch k_len and is_signed.
  - Go to LOAD, or to DRAIN if k_len = 0, which yields an all-zero C.
- start outside IDLE is ignored.
- LOAD:
  - in_ready = 1.
  - Each accepted step (in_valid & in_ready) is one array advance.
  - No advance when in_valid = 0: every skew, pipeline and PE register holds.
  - After the K-th accepted step, go to FLUSH.
- FLUSH: 2N−2 unconditional advances with zero operands injected, then DRAIN.
- Skew: lane i of a_col is delayed i advances before column 0; lane j of b_row is delayed j advances before row 0.
- PE(i,j) on every advance:
  - Forwards a right and b down, one register each.
  - Adds the product of its a and b inputs to its accumulator.
- Step k meets at PE(i,j) on advance k+i+j (0-based), so every product lands by advance K+2N−3.
- Arithmetic:
  - Product is 2·DATA_W bits, signed or unsigned per the latched is_signed.
  - Product is sign- or zero-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation.
- DRAIN:
  - Rows 0..N−1 are presented in order.
  - out_row and out_data stay stable while out_valid & !out_ready.
  - The row advances on handshake.
  - After row N−1 is accepted: pulse done, go to IDLE.
- Accumulators hold their values in IDLE until the next start.

## Timing
- Reset values:
  - State IDLE.
  - in_ready, out_valid, busy, done = 0.
  - out_row = 0, out_data = 0.
  - All accumulators and skew/forward registers = 0.
- Reset mid-job aborts immediately with the same values; no done is issued.
- in_ready, out_valid and busy are registered state decodes; no combinational path from in_valid or out_ready.
- First out_valid rises the cycle after the last FLUSH advance.
- Minimum latency from start to done, with no stalls and out_ready held high: 1 + K + (2N−2) + N cycles.
- done asserts the cycle after the row N−1 handshake; busy falls in that same cycle.
- start is accepted in the cycle done is high: back-to-back jobs.
- in_valid while not in LOAD: data ignored, in_ready = 0.

## Structure
- Shared package `mm_pkg`:
  - State enum.
  - Defaults for N, DATA_W, ACC_W.
  - Helper localparam for flush length 2N−2.
- Sub-module `mm_pe`:
  - Ports: clk, rst_n, adv, clr, is_signed, a_in, b_in, a_out, b_out, acc.
  - Instantiated N² times via generate.
- Skew delay lines and FSM live in the top level.

## Test plan
- N=4, K=4, A = identity, B[k][j] = 4k+j+1, no stalls → rows read back equal B; done at cycle 1+4+6+4 after start.
- N=4, K=3, A[i][k] = i+k, B[k][j] = k−j, is_signed=1 → C[i][j] = Σ(i+k)(k−j), e.g. C[0][3] = −4, C[3][0] = 14; negative lanes correct.
- is_signed=0, K=2, all operands 255 → every C = 130050; with is_signed=1 same bits → every C = 2.
- Random in_valid gaps (50%) in LOAD and random out_ready in DRAIN → results match the no-stall run; out_data stable while stalled.
- k_len=0 → no in_ready; 4 all-zero rows, then done. start pulsed during LOAD → ignored.
- rst_n low during FLUSH → next cycle all outputs 0, state IDLE; a new job with K=1, A=B=all 1s → every C = 1, with no residue from the aborted job.
